// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus a carry flop, LSB first.
// Computes {carry, sum} = a + b + cin over WIDTH clock cycles with a start/done handshake.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  begin an addition (sampled in IDLE or DONE only)
//   a, b   operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   busy   high while shifting
//   done   one-cycle pulse when sum/carry are valid
//   sum    result, held until the next result is produced
//   carry  carry-out of bit WIDTH-1, held like sum
//   ovf    signed overflow (only when SERIAL_ADDER_OVF_EN is defined)
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output and its logic.

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, b_sr_q;
  // Holds the WIDTH-1 sum bits produced before the final shift; the last bit
  // comes straight from the adder cell when the result is committed.
  logic [WIDTH-2:0] sum_sr_q;
  logic             c_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic             bit_s, bit_c;
  logic             accept, last;
  logic [WIDTH-1:0] sum_full;

  // Full-adder cell.
  assign bit_s = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign bit_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);

  assign accept   = ((state_q == StIdle) || (state_q == StDone)) && start;
  assign last     = (state_q == StShift) && (cnt_q == CntLast);
  assign sum_full = {bit_s, sum_sr_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
    end else if (accept) begin
      a_sr_q   <= a;
      b_sr_q   <= b;
      sum_sr_q <= '0;
      c_q      <= cin;
      cnt_q    <= '0;
    end else if (state_q == StShift) begin
      a_sr_q   <= a_sr_q >> 1;
      b_sr_q   <= b_sr_q >> 1;
      sum_sr_q <= sum_full[WIDTH-1:1];
      c_q      <= bit_c;
      if (last) begin
        // Outputs only move here, so they stay stable through IDLE and DONE.
        sum_q   <= sum_full;
        carry_q <= bit_c;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // On the last shift c_q is the carry into the MSB and bit_c the carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= c_q ^ bit_c;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy  = (state_q == StShift);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, carry8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start2 = 1'b0, cin2 = 1'b0, busy2, done2, carry2;
  logic [1:0] a2 = '0, b2 = '0, sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .carry(carry2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer addition; signed overflow from operand/result signs.
  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y,
                                          input logic c);
    return 9'(int'(x) + int'(y) + int'(c));
  endfunction

  function automatic logic ref_ovf8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int sx, sy, ss;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ss = sx + sy + int'(c);
    return (ss > 127) || (ss < -128);
  endfunction

  // Waits (bounded) for done8 at negedges; returns edges counted since the accepting edge.
  task automatic wait_done8(output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1'b1;
    while (done8 !== 1'b1 && cyc < 40) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result8(input string tag, input logic [7:0] x, input logic [7:0] y,
                               input logic c);
    logic [8:0] r;
    r = ref_add8(x, y, c);
    chk({tag, " sum"}, 32'(sum8), 32'(r[7:0]));
    chk({tag, " carry"}, 32'(carry8), 32'(r[8]));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, " ovf"}, 32'(ovf8), 32'(ref_ovf8(x, y, c)));
`endif
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input string tag);
    int cyc;
    bit busy_ok;
    logic [8:0] r;
    r = ref_add8(x, y, c);
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    // Scramble inputs after acceptance; they must not affect the result.
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    wait_done8(cyc, busy_ok);
    chk({tag, " edges to done"}, 32'(cyc), 32'd9);
    chk({tag, " busy during shift"}, 32'(busy_ok), 32'd1);
    chk({tag, " busy at done"}, 32'(busy8), 32'd0);
    check_result8(tag, x, y, c);
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(done8), 32'd0);
    chk({tag, " sum held"}, 32'(sum8), 32'(r[7:0]));
  endtask

  initial begin
    int cyc, dones;
    bit busy_ok;
    logic [7:0] x, y;
    logic c;

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset sum", 32'(sum8), 32'd0);
    chk("reset carry", 32'(carry8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset ovf", 32'(ovf8), 32'd0);
`endif
    rst_n = 1'b1;

    run8(8'h00, 8'h00, 1'b0, "zero");
    run8(8'hFF, 8'h01, 1'b0, "wrap");
    run8(8'h7F, 8'h01, 1'b0, "sovf");
    run8(8'hA5, 8'h5A, 1'b1, "cin prop");

    // start pulsed mid-shift must be ignored.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      if (done8 === 1'b1) begin
        dones++;
        chk("ignored start sum", 32'(sum8), 32'h46);
        chk("ignored start carry", 32'(carry8), 32'd0);
      end
      @(negedge clk);
    end
    chk("ignored start done count", 32'(dones), 32'd1);

    // Reset in the middle of a shift.
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy8), 32'd0);
    chk("midreset done", 32'(done8), 32'd0);
    chk("midreset sum", 32'(sum8), 32'd0);
    chk("midreset carry", 32'(carry8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("midreset ovf", 32'(ovf8), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    chk("midreset no done", 32'(dones), 32'd0);
    run8(8'h5A, 8'h3C, 1'b0, "post reset");

    // Back-to-back: start held high, new operands taken on the DONE edge.
    @(negedge clk);
    a8 = 8'h81; b8 = 8'h92; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    wait_done8(cyc, busy_ok);
    chk("b2b first edges", 32'(cyc), 32'd9);
    check_result8("b2b first", 8'h81, 8'h92, 1'b1);
    a8 = 8'h3E; b8 = 8'hC7; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(cyc, busy_ok);
    chk("b2b period", 32'(cyc), 32'd9);
    chk("b2b busy", 32'(busy_ok), 32'd1);
    check_result8("b2b second", 8'h3E, 8'hC7, 1'b0);

    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      run8(x, y, c, "rand");
    end

    // WIDTH=2 exhaustive.
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
          @(negedge clk);
          start2 = 1'b0;
          cyc = 1;
          while (done2 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
          end
          chk("w2 edges to done", 32'(cyc), 32'd3);
          chk("w2 result", 32'({carry2, sum2}), 32'(ia + ib + ic));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
